word_align: RTL and testbench
=============================

Name: word_align

Overview:
- Byte-boundary aligner directly downstream of the IDELAY bit-alignment controller.
- Consumes the 8-bit deserialized word stream D_OUT_P once bit alignment reports delay_ready.
- Searches all 8 bit rotations for a sync/idle byte, confirms the boundary, then emits byte-aligned data with lock status and lock-loss monitoring.
- Offers a manual override of the rotation for debug.

Parameters:
- SYNC_PATTERN, 8'hAC, idle/sync byte to search for; bit 0 is earliest in time.
- LOCK_COUNT, 16, consecutive matches at one offset required to declare lock (2..255).
- UNLOCK_COUNT, 4, consecutive monitored misses in LOCKED that drop lock (1..255).

Ports:
- clk160  in  1  word clock, one deserialized byte per cycle.
- rstb  in  1  asynchronous active-low reset.
- D_OUT_P  in  8  deserialized word; bit 0 earliest, bit 7 latest.
- delay_ready  in  1  bit alignment done; low forces IDLE.
- monitor_en  in  1  link is sending idles; enables miss counting in LOCKED.
- manual_mode  in  1  1 = use manual_offset and skip search.
- manual_offset  in  3  rotation used in manual mode.
- reset_counters  in  1  synchronous clear of relock_count.
- data_out  out  8  aligned byte.
- data_valid  out  1  data_out is aligned (LOCKED or manual).
- bit_offset  out  3  rotation in use.
- locked  out  1  state is LOCKED.
- relock_count  out  16  LOCKED→SEARCH transitions; saturates at 16'hFFFF.

Behaviour:
- Reset (rstb low, async): all outputs 0, state IDLE, d_prev=0, match/miss counters 0.
- Window and candidate:
  - d_prev <= D_OUT_P every cycle, all states.
  - w[15:0] = {D_OUT_P, d_prev}; cand(k) = w[k+7:k], k=0..7.
- Output path:
  - data_out <= cand(bit_offset) every cycle, so latency is 1 clk after the word holding the byte's newest bit.
  - data_valid <= (next state == LOCKED) || manual_mode&&delay_ready.
- States:
  - IDLE: stay while !delay_ready. Else go MANUAL if manual_mode, otherwise SEARCH.
  - SEARCH:
    - Compare all 8 candidates against SYNC_PATTERN in the same cycle.
    - If any match, the lowest k wins: bit_offset <= k, match_cnt <= 1, go CONFIRM.
    - No match: stay.
  - CONFIRM: compare cand(bit_offset) each cycle.
    - Match: match_cnt+1; when match_cnt+1 == LOCK_COUNT go LOCKED.
    - Miss: match_cnt <= 0, go SEARCH.
    - bit_offset is held in CONFIRM.
  - LOCKED: bit_offset frozen.
    - With monitor_en=1: a miss increments miss_cnt; a match clears it.
    - When miss_cnt+1 == UNLOCK_COUNT: go SEARCH, miss_cnt <= 0, relock_count+1 (saturating).
    - With monitor_en=0: miss_cnt held, no checks.
  - MANUAL: bit_offset <= manual_offset every cycle; locked=0.
- Mode changes:
  - Exit to IDLE when manual_mode falls.
  - manual_mode rising in SEARCH/CONFIRM/LOCKED → MANUAL next cycle. No relock_count increment.
- Priority, highest first: !delay_ready (→IDLE from any state, same cycle registered; counters cleared; relock_count kept) > manual_mode > pattern logic.
- reset_counters clears relock_count synchronously. It wins over a simultaneous increment.
- locked is registered, equal to (state==LOCKED).
- data_valid falls on the same edge the state leaves LOCKED.
- Counters: match_cnt and miss_cnt are 8 bits each; no wrap is possible given the parameter ranges.
- Patterns with rotational symmetry (e.g. 8'hAA) are a user error. Lowest-k resolves them deterministically.

Test Plan:
- Offset 0:
  - Stimulus: rstb low→high, delay_ready=1, stream 8'hAC every cycle.
  - Response: SEARCH→CONFIRM at k=0. locked=1 after 16 matching cycles. data_out=8'hAC with data_valid=1 the next cycle.
- Rotated stream:
  - Stimulus: bitstream of repeated 8'hAC delayed by 3 bits.
  - Response: bit_offset=3, locked=1, data_out=8'hAC. Payload byte 8'h5E sent at offset 3 appears as data_out=8'h5E 1 clk later.
- Confirm failure:
  - Stimulus: 10 matches then one corrupted word during CONFIRM.
  - Response: back to SEARCH, locked stays 0, relock_count=0. Relock after 16 fresh matches.
- Lock loss:
  - Stimulus: locked, monitor_en=1, 3 misses, 1 match, then 4 misses.
  - Response: stays locked after the first 3 misses. Drops to SEARCH on the 4th consecutive miss. relock_count=1, data_valid=0 same edge.
  - Stimulus: same misses with monitor_en=0.
  - Response: locked stays 1.
- delay_ready / reset mid-operation:
  - Stimulus: drop delay_ready while LOCKED.
  - Response: IDLE, locked=0, relock_count unchanged.
  - Stimulus: assert rstb low asynchronously mid-CONFIRM.
  - Response: all outputs 0 immediately.
  - Stimulus: reset_counters coincident with an unlock.
  - Response: relock_count=0.
- Manual:
  - Stimulus: manual_mode=1, manual_offset=5.
  - Response: bit_offset=5, data_valid=1, locked=0, data_out=cand(5).
  - Stimulus: manual_mode→0.
  - Response: IDLE then SEARCH.

Source files
------------

// File: rtl/word_align_if.sv
// Port bundle for the byte aligner: deserialized input word, control, and aligned output/status.
interface word_align_if;
  logic [7:0]  D_OUT_P;
  logic        delay_ready;
  logic        monitor_en;
  logic        manual_mode;
  logic [2:0]  manual_offset;
  logic        reset_counters;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [2:0]  bit_offset;
  logic        locked;
  logic [15:0] relock_count;

  modport master (
    output D_OUT_P, delay_ready, monitor_en, manual_mode, manual_offset, reset_counters,
    input  data_out, data_valid, bit_offset, locked, relock_count
  );

  modport slave (
    input  D_OUT_P, delay_ready, monitor_en, manual_mode, manual_offset, reset_counters,
    output data_out, data_valid, bit_offset, locked, relock_count
  );
endinterface

// File: rtl/word_align.sv
// Byte-boundary aligner: finds the sync byte among all 8 rotations, confirms it,
// then emits aligned bytes while monitoring idles for loss of lock.
module word_align #(
  parameter logic [7:0] SYNC_PATTERN = 8'hAC,
  parameter int         LOCK_COUNT   = 16,
  parameter int         UNLOCK_COUNT = 4
) (
  input  logic        clk160,
  input  logic        rstb,
  word_align_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEARCH, ST_CONFIRM, ST_LOCKED, ST_MANUAL
  } state_t;

  localparam logic [7:0] LOCK_CNT8   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_CNT8 = 8'(UNLOCK_COUNT);

  state_t      state_q, state_d;
  logic [7:0]  d_prev_q;
  logic [2:0]  bit_offset_q, bit_offset_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  miss_cnt_q, miss_cnt_d;
  logic [15:0] relock_q, relock_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        locked_q, locked_d;

  // Two-word window; bit 0 of the previous word is the earliest bit in time.
  logic [15:0] win;
  logic [7:0]  cand [8];
  logic [7:0]  hit;
  logic [7:0]  cand_sel;
  logic [2:0]  first_k;

  assign win = {bus.D_OUT_P, d_prev_q};

  for (genvar gi = 0; gi < 8; gi++) begin : g_cand
    assign cand[gi] = win[gi+7:gi];
    assign hit[gi]  = (win[gi+7:gi] == SYNC_PATTERN);
  end

  assign cand_sel = cand[bit_offset_q];

  always_comb begin
    first_k = '0;
    for (int i = 7; i >= 0; i--) begin
      if (hit[i]) first_k = 3'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_offset_d = bit_offset_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    relock_d     = relock_q;

    if (!bus.delay_ready) begin
      state_d     = ST_IDLE;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = bus.manual_mode ? ST_MANUAL : ST_SEARCH;
    end else if (state_q == ST_MANUAL) begin
      bit_offset_d = bus.manual_offset;
      if (!bus.manual_mode) state_d = ST_IDLE;
    end else if (bus.manual_mode) begin
      state_d     = ST_MANUAL;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (|hit) begin
            bit_offset_d = first_k;
            match_cnt_d  = 8'd1;
            state_d      = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (cand_sel == SYNC_PATTERN) begin
            if (match_cnt_q + 8'd1 == LOCK_CNT8) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = '0;
            state_d     = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Misses only count while the far end is known to be sending idles.
          if (bus.monitor_en) begin
            if (cand_sel == SYNC_PATTERN) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 8'd1 == UNLOCK_CNT8) begin
              state_d    = ST_SEARCH;
              miss_cnt_d = '0;
              if (relock_q != 16'hFFFF) relock_d = relock_q + 16'd1;
            end else begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (bus.reset_counters) relock_d = '0;

    data_out_d   = cand_sel;
    locked_d     = (state_d == ST_LOCKED);
    data_valid_d = (state_d == ST_LOCKED) || (bus.manual_mode && bus.delay_ready);
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      d_prev_q     <= '0;
      bit_offset_q <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      relock_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_prev_q     <= bus.D_OUT_P;
      bit_offset_q <= bit_offset_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      relock_q     <= relock_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.bit_offset   = bit_offset_q;
  assign bus.locked       = locked_q;
  assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_word_align.sv
// Bench for word_align: bit-stream generator feeding a bit-history reference model,
// directed scenarios followed by a randomized soak.
module tb_word_align;
  localparam int         LOCK_COUNT   = 16;
  localparam int         UNLOCK_COUNT = 4;
  localparam logic [7:0] SYNC         = 8'hAC;

  logic clk160 = 1'b0;
  logic rstb   = 1'b1;
  always #3 clk160 = ~clk160;

  word_align_if bus();

  word_align #(
    .SYNC_PATTERN(SYNC),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .clk160(clk160),
    .rstb  (rstb),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Source bit stream (time order) and the model's view of the received bits.
  bit        srcq[$];
  logic [7:0] injq[$];
  bit        gen_rand;
  bit        histq[$];

  string      m_st;
  int         m_off, m_match, m_miss, m_relock;
  logic [7:0] e_dout;
  bit         e_valid, e_locked;

  function automatic logic [7:0] mcand(input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = histq[k+j];
    return r;
  endfunction

  task automatic set_phase(input int s);
    srcq.delete();
    repeat (s) srcq.push_back(1'($urandom));
  endtask

  task automatic drive_word();
    logic [7:0] b;
    logic [7:0] w;
    while (srcq.size() < 8) begin
      if (injq.size() > 0) b = injq.pop_front();
      else if (gen_rand)   b = 8'($urandom);
      else                 b = SYNC;
      for (int j = 0; j < 8; j++) srcq.push_back(b[j]);
    end
    for (int j = 0; j < 8; j++) w[j] = srcq.pop_front();
    bus.D_OUT_P = w;
  endtask

  task automatic model_reset();
    histq.delete();
    repeat (8) histq.push_back(1'b0);
    m_st = "IDLE"; m_off = 0; m_match = 0; m_miss = 0; m_relock = 0;
  endtask

  task automatic model_step();
    bit found;
    for (int j = 0; j < 8; j++) histq.push_back(bus.D_OUT_P[j]);
    while (histq.size() > 16) void'(histq.pop_front());
    e_dout = mcand(m_off);
    if (!bus.delay_ready) begin
      m_st = "IDLE"; m_match = 0; m_miss = 0;
    end else if (m_st == "IDLE") begin
      m_st = bus.manual_mode ? "MANUAL" : "SEARCH";
    end else if (m_st == "MANUAL") begin
      m_off = bus.manual_offset;
      if (!bus.manual_mode) m_st = "IDLE";
    end else if (bus.manual_mode) begin
      m_st = "MANUAL"; m_match = 0; m_miss = 0;
    end else if (m_st == "SEARCH") begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && mcand(k) == SYNC) begin
          found = 1; m_off = k; m_match = 1; m_st = "CONFIRM";
        end
      end
    end else if (m_st == "CONFIRM") begin
      if (mcand(m_off) == SYNC) begin
        m_match++;
        if (m_match == LOCK_COUNT) begin m_st = "LOCKED"; m_match = 0; end
      end else begin
        m_match = 0; m_st = "SEARCH";
      end
    end else if (bus.monitor_en) begin
      if (mcand(m_off) == SYNC) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == UNLOCK_COUNT) begin
          m_st = "SEARCH"; m_miss = 0;
          if (m_relock < 65535) m_relock++;
        end
      end
    end
    if (bus.reset_counters) m_relock = 0;
    e_locked = (m_st == "LOCKED");
    e_valid  = e_locked || (bus.manual_mode && bus.delay_ready);
  endtask

  task automatic tick();
    drive_word();
    model_step();
    @(posedge clk160);
    #1;
    chk("data_out",     32'(bus.data_out),     32'(e_dout));
    chk("data_valid",   32'(bus.data_valid),   32'(e_valid));
    chk("locked",       32'(bus.locked),       32'(e_locked));
    chk("bit_offset",   32'(bus.bit_offset),   32'(m_off));
    chk("relock_count", 32'(bus.relock_count), 32'(m_relock));
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #1;
    chk("rst_data_out",   32'(bus.data_out),     0);
    chk("rst_data_valid", 32'(bus.data_valid),   0);
    chk("rst_locked",     32'(bus.locked),       0);
    chk("rst_bit_offset", 32'(bus.bit_offset),   0);
    chk("rst_relock",     32'(bus.relock_count), 0);
    @(posedge clk160);
    #1;
    model_reset();
    rstb = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.D_OUT_P = '0; bus.delay_ready = 1'b0; bus.monitor_en = 1'b0;
    bus.manual_mode = 1'b0; bus.manual_offset = '0; bus.reset_counters = 1'b0;
    gen_rand = 0;
    model_reset();
    #5;
    do_reset();

    $display("scenario: offset 0 lock");
    bus.delay_ready = 1'b1; set_phase(0);
    repeat (22) tick();
    chk("s1_locked", 32'(bus.locked), 1);
    chk("s1_offset", 32'(bus.bit_offset), 0);
    chk("s1_dout",   32'(bus.data_out), 32'h AC);

    $display("scenario: stream rotated by 3 bits, payload 5E");
    do_reset();
    bus.delay_ready = 1'b1; set_phase(3);
    repeat (25) tick();
    chk("s2_locked", 32'(bus.locked), 1);
    chk("s2_offset", 32'(bus.bit_offset), 3);
    chk("s2_dout",   32'(bus.data_out), 32'hAC);
    injq.push_back(8'h5E);
    seen = 0;
    repeat (4) begin
      tick();
      if (bus.data_out == 8'h5E && bus.data_valid) seen = 1;
    end
    chk("s2_payload", 32'(seen), 1);

    $display("scenario: confirm failure then relock");
    do_reset();
    bus.delay_ready = 1'b1; set_phase(0);
    repeat (12) tick();
    injq.push_back(8'h00);
    repeat (3) tick();
    chk("s3_locked", 32'(bus.locked), 0);
    chk("s3_relock", 32'(bus.relock_count), 0);
    repeat (20) tick();
    chk("s3_relocked", 32'(bus.locked), 1);

    $display("scenario: lock loss with monitor_en=1");
    bus.monitor_en = 1'b1;
    injq = '{8'h00, 8'h00, 8'h00, SYNC, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (7) tick();
    chk("s4_hold", 32'(bus.locked), 1);
    repeat (2) tick();
    chk("s4_drop",   32'(bus.locked), 0);
    chk("s4_valid",  32'(bus.data_valid), 0);
    chk("s4_relock", 32'(bus.relock_count), 1);
    repeat (20) tick();

    $display("scenario: same misses with monitor_en=0");
    bus.monitor_en = 1'b0;
    injq = '{8'h00, 8'h00, 8'h00, SYNC, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (12) tick();
    chk("s5_locked", 32'(bus.locked), 1);
    chk("s5_relock", 32'(bus.relock_count), 1);

    $display("scenario: delay_ready drop while locked");
    bus.delay_ready = 1'b0;
    tick();
    chk("s6_locked", 32'(bus.locked), 0);
    chk("s6_relock", 32'(bus.relock_count), 1);
    bus.delay_ready = 1'b1;
    repeat (20) tick();
    chk("s6_relocked", 32'(bus.locked), 1);

    $display("scenario: reset_counters coincident with unlock");
    bus.monitor_en = 1'b1;
    injq = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (4) tick();
    chk("s7_pre_locked", 32'(bus.locked), 1);
    bus.reset_counters = 1'b1;
    tick();
    bus.reset_counters = 1'b0;
    chk("s7_locked", 32'(bus.locked), 0);
    chk("s7_relock", 32'(bus.relock_count), 0);

    $display("scenario: async reset mid-confirm");
    bus.monitor_en = 1'b0; bus.delay_ready = 1'b0;
    tick();
    set_phase(5); bus.delay_ready = 1'b1;
    repeat (6) tick();
    chk("s8_pre_offset", 32'(bus.bit_offset), 5);
    #2;
    do_reset();

    $display("scenario: manual offset 5");
    bus.delay_ready = 1'b1; bus.manual_mode = 1'b1; bus.manual_offset = 3'd5;
    repeat (4) tick();
    chk("s9_offset", 32'(bus.bit_offset), 5);
    chk("s9_valid",  32'(bus.data_valid), 1);
    chk("s9_locked", 32'(bus.locked), 0);
    chk("s9_dout",   32'(bus.data_out), 32'hAC);
    bus.manual_mode = 1'b0;
    tick();
    chk("s9_exit_valid", 32'(bus.data_valid), 0);
    repeat (22) tick();
    chk("s9_search_lock", 32'(bus.locked), 1);

    $display("scenario: randomized soak");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) bus.delay_ready = ~bus.delay_ready;
      if ($urandom_range(0, 299) == 0) bus.manual_mode = ~bus.manual_mode;
      if ($urandom_range(0, 49) == 0)  bus.monitor_en = ~bus.monitor_en;
      if ($urandom_range(0, 19) == 0)  bus.manual_offset = 3'($urandom);
      bus.reset_counters = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0)  gen_rand = ~gen_rand;
      if ($urandom_range(0, 149) == 0) srcq.push_back(1'($urandom));
      if ($urandom_range(0, 29) == 0)  injq.push_back(8'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
